// File: rtl/b1i_signal_gen.sv
// BeiDou B1I IF stimulus: G1/G2 PRN chips, 8x upsampled, BPSK on an NCO carrier, 4-bit signed samples.
// First sample valid two cycles after start (code_phase=0); while sample_ready is low every output holds.
module b1i_signal_gen #(
  parameter int B1I_CODE_LENGTH      = 2046,
  parameter int B1I_SAMPLES_PER_CHIP = 8,
  parameter int B1I_SAMPLES_PER_CODE = 16368
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  g2_tap_a,
  input  logic [3:0]  g2_tap_b,
  input  logic [10:0] code_phase,
  input  logic [31:0] carrier_fcw,
  input  logic [7:0]  num_codes,
  output logic [3:0]  sample_out,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        chip_out,
  output logic        epoch,
  output logic        busy,
  output logic        done
);

  localparam int SIC_W = $clog2(B1I_SAMPLES_PER_CHIP);
  localparam int SMP_W = $clog2(B1I_SAMPLES_PER_CODE);
  localparam logic [10:0]      CHIP_LAST = 11'(B1I_CODE_LENGTH - 1);
  localparam logic [SIC_W-1:0] SIC_LAST  = SIC_W'(B1I_SAMPLES_PER_CHIP - 1);
  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(B1I_SAMPLES_PER_CODE - 1);
  localparam logic [11:1]      LFSR_INIT = 11'b010_1010_1010;

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_STREAM, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [11:1]        r_g1, r_g2;
  logic [10:0]        r_chip_idx, r_seek_cnt;
  logic [SIC_W-1:0]   r_sic;
  logic [SMP_W-1:0]   r_smp_cnt;
  logic [7:0]         r_period;
  logic [31:0]        r_nco;
  logic [3:0]         r_tap_a, r_tap_b;
  logic [10:0]        r_code_phase;
  logic [31:0]        r_fcw;
  logic [7:0]         r_num_codes;
  logic [3:0]         r_sample;
  logic               r_chip, r_epoch, r_valid;

  // Out-of-range tap selects land on the zero padding
  function automatic logic f_tap(input logic [11:1] g, input logic [3:0] t);
    logic [15:0] ext;
    ext = {4'b0000, g, 1'b0};
    return ext[t];
  endfunction

  function automatic logic [3:0] f_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    f_lut = 4'b0111;
      3'd1:    f_lut = 4'b0101;
      3'd2:    f_lut = 4'b0000;
      3'd3:    f_lut = 4'b1011;
      3'd4:    f_lut = 4'b1001;
      3'd5:    f_lut = 4'b1011;
      3'd6:    f_lut = 4'b0000;
      default: f_lut = 4'b0101;
    endcase
  endfunction

  logic              w_g1_fb, w_g2_fb, w_chip_wrap;
  logic [11:1]       w_g1_adv, w_g2_adv, w_g1_nxt, w_g2_nxt;
  logic [10:0]       w_chip_idx_adv;
  logic              w_xfer, w_sic_wrap, w_smp_wrap, w_last, w_seek_end;
  logic [31:0]       w_nco_nxt;
  logic [SMP_W-1:0]  w_smp_nxt;
  logic [2:0]        w_out_ph;
  logic [11:1]       w_out_g1, w_out_g2;
  logic [SMP_W-1:0]  w_out_smp;
  logic              w_out_chip, w_out_epoch;
  logic [3:0]        w_lut, w_out_sample;

  assign w_g1_fb        = r_g1[1] ^ r_g1[7] ^ r_g1[8] ^ r_g1[9] ^ r_g1[10] ^ r_g1[11];
  assign w_g2_fb        = r_g2[1] ^ r_g2[2] ^ r_g2[3] ^ r_g2[4] ^ r_g2[5] ^ r_g2[8] ^ r_g2[9] ^ r_g2[11];
  assign w_chip_wrap    = (r_chip_idx == CHIP_LAST);
  assign w_g1_adv       = w_chip_wrap ? LFSR_INIT : {r_g1[10:1], w_g1_fb};
  assign w_g2_adv       = w_chip_wrap ? LFSR_INIT : {r_g2[10:1], w_g2_fb};
  assign w_chip_idx_adv = w_chip_wrap ? 11'd0 : r_chip_idx + 11'd1;

  assign w_xfer     = r_valid & sample_ready;
  assign w_sic_wrap = (r_sic == SIC_LAST);
  assign w_smp_wrap = (r_smp_cnt == SMP_LAST);
  assign w_last     = w_smp_wrap && (({1'b0, r_period} + 9'd1) == {1'b0, r_num_codes});
  assign w_seek_end = (r_seek_cnt == r_code_phase);
  assign w_nco_nxt  = r_nco + r_fcw;
  assign w_g1_nxt   = w_sic_wrap ? w_g1_adv : r_g1;
  assign w_g2_nxt   = w_sic_wrap ? w_g2_adv : r_g2;
  assign w_smp_nxt  = w_smp_wrap ? '0 : r_smp_cnt + 1'b1;

  // Output registers are loaded from current state on the priming cycle, from post-transfer state afterwards
  assign w_out_ph     = r_valid ? w_nco_nxt[31:29] : r_nco[31:29];
  assign w_out_g1     = r_valid ? w_g1_nxt : r_g1;
  assign w_out_g2     = r_valid ? w_g2_nxt : r_g2;
  assign w_out_smp    = r_valid ? w_smp_nxt : r_smp_cnt;
  assign w_out_chip   = w_out_g1[11] ^ f_tap(w_out_g2, r_tap_a) ^ f_tap(w_out_g2, r_tap_b);
  assign w_out_epoch  = (w_out_smp == '0);
  assign w_lut        = f_lut(w_out_ph);
  assign w_out_sample = w_out_chip ? w_lut : (4'd0 - w_lut);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_SEEK;
      S_SEEK:   if (w_seek_end) w_state_nxt = (r_num_codes == 8'd0) ? S_DONE : S_STREAM;
      S_STREAM: if (w_xfer && w_last) w_state_nxt = S_DONE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_g1         <= LFSR_INIT;
      r_g2         <= LFSR_INIT;
      r_chip_idx   <= '0;
      r_seek_cnt   <= '0;
      r_sic        <= '0;
      r_smp_cnt    <= '0;
      r_period     <= '0;
      r_nco        <= '0;
      r_tap_a      <= '0;
      r_tap_b      <= '0;
      r_code_phase <= '0;
      r_fcw        <= '0;
      r_num_codes  <= '0;
      r_sample     <= '0;
      r_chip       <= 1'b0;
      r_epoch      <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_tap_a      <= g2_tap_a;
          r_tap_b      <= g2_tap_b;
          r_code_phase <= code_phase;
          r_fcw        <= carrier_fcw;
          r_num_codes  <= num_codes;
          r_g1         <= LFSR_INIT;
          r_g2         <= LFSR_INIT;
          r_chip_idx   <= '0;
          r_seek_cnt   <= '0;
          r_sic        <= '0;
          r_smp_cnt    <= '0;
          r_period     <= '0;
          r_nco        <= '0;
          r_sample     <= '0;
          r_chip       <= 1'b0;
          r_epoch      <= 1'b0;
          r_valid      <= 1'b0;
        end
        S_SEEK: if (!w_seek_end) begin
          r_g1       <= w_g1_adv;
          r_g2       <= w_g2_adv;
          r_chip_idx <= w_chip_idx_adv;
          r_seek_cnt <= r_seek_cnt + 11'd1;
        end
        S_STREAM: begin
          if (!r_valid) begin
            r_valid  <= 1'b1;
            r_sample <= w_out_sample;
            r_chip   <= w_out_chip;
            r_epoch  <= w_out_epoch;
          end else if (w_xfer) begin
            r_nco     <= w_nco_nxt;
            r_sic     <= w_sic_wrap ? '0 : r_sic + 1'b1;
            r_g1      <= w_g1_nxt;
            r_g2      <= w_g2_nxt;
            r_smp_cnt <= w_smp_nxt;
            if (w_sic_wrap) r_chip_idx <= w_chip_idx_adv;
            if (w_smp_wrap) r_period <= r_period + 8'd1;
            if (w_last) begin
              r_valid  <= 1'b0;
              r_sample <= '0;
              r_chip   <= 1'b0;
              r_epoch  <= 1'b0;
            end else begin
              r_sample <= w_out_sample;
              r_chip   <= w_out_chip;
              r_epoch  <= w_out_epoch;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign chip_out     = r_chip;
  assign epoch        = r_epoch;

endmodule
